// File: rtl/flags_pkg.sv
// Shared flag bit positions and carry-select encodings for the ALU flags unit.
package flags_pkg;

    localparam int unsigned FLAG_AC    = 0;
    localparam int unsigned FLAG_LC    = 1;
    localparam int unsigned FLAG_Z     = 2;
    localparam int unsigned FLAG_S     = 3;
    localparam int unsigned FLAG_V     = 4;
    localparam int unsigned FLAG_COUNT = 5;

    localparam logic [1:0] CSEL_ZERO  = 2'b00;
    localparam logic [1:0] CSEL_ONE   = 2'b01;
    localparam logic [1:0] CSEL_ARITH = 2'b10;
    localparam logic [1:0] CSEL_LOGIC = 2'b11;

endpackage

// File: rtl/flag_stack.sv
// Shift-register LIFO for saved flag words; the top-of-stack entry is always slot 0.
module flag_stack #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned FLAG_COUNT  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [FLAG_COUNT-1:0] din,
    output logic                  full,
    output logic                  empty,
    output logic [FLAG_COUNT-1:0] top
);

    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

    logic [CW-1:0]         r_count;
    logic [FLAG_COUNT-1:0] r_mem [STACK_DEPTH];

    // Caller guarantees push/pop are mutually exclusive and never overflow/underflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (push) begin
            r_count <= r_count + CW'(1);
        end else if (pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[0] <= din;
            for (int unsigned i = 1; i < STACK_DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end else if (pop) begin
            for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) begin
                r_mem[i] <= r_mem[i+1];
            end
        end
    end

    assign full  = (r_count == CW'(STACK_DEPTH));
    assign empty = (r_count == '0);
    assign top   = r_mem[0];

endmodule

// File: rtl/flags_unit.sv
// ALU status-flag register with masked updates, direct load, save stack and carry select.
module flags_unit
    import flags_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic                  stall,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [WIDTH-1:0]      lhs_in,
    input  logic [WIDTH-1:0]      rhs_in,
    input  logic                  arith_carry_in,
    input  logic                  logic_carry_in,
    input  logic [1:0]            carry_sel,
    input  logic [FLAG_COUNT-1:0] update_mask,
    input  logic                  load_en,
    input  logic [FLAG_COUNT-1:0] load_flags,
    input  logic                  push,
    input  logic                  pop,
    output logic [FLAG_COUNT-1:0] flags_o,
    output logic [1:0]            carry_sel_d,
    output logic                  carry_out,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  stack_err
);

    logic [FLAG_COUNT-1:0] r_flags;
    logic [1:0]            r_csel_d;
    logic                  r_err;

    logic [FLAG_COUNT-1:0] w_calc;
    logic [FLAG_COUNT-1:0] w_masked;
    logic [FLAG_COUNT-1:0] w_flags_nxt;
    logic [FLAG_COUNT-1:0] w_top;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_only;
    logic                  w_pop_only;
    logic                  w_do_push;
    logic                  w_do_pop;
    logic                  w_err_evt;

    always_comb begin
        w_calc          = '0;
        w_calc[FLAG_V]  = (lhs_in[WIDTH-1] ^ data_in[WIDTH-1]) & (data_in[WIDTH-1] ^ rhs_in[WIDTH-1]);
        w_calc[FLAG_S]  = data_in[WIDTH-1];
        w_calc[FLAG_Z]  = ~|data_in;
        w_calc[FLAG_LC] = logic_carry_in;
        w_calc[FLAG_AC] = arith_carry_in;
    end

    assign w_masked    = (r_flags & ~update_mask) | (w_calc & update_mask);
    assign w_push_only = push & ~pop;
    assign w_pop_only  = pop & ~push;
    assign w_do_push   = ~stall & w_push_only & ~w_full;
    assign w_do_pop    = ~stall & w_pop_only & ~w_empty;
    assign w_err_evt   = ~stall & ((push & pop) | (w_push_only & w_full) | (w_pop_only & w_empty));

    // A lone pop owns the flag register even when it fails; a push/pop conflict does not.
    always_comb begin
        w_flags_nxt = r_flags;
        if (w_pop_only) begin
            if (!w_empty) begin
                w_flags_nxt = w_top;
            end
        end else if (load_en) begin
            w_flags_nxt = load_flags;
        end else if (valid_in) begin
            w_flags_nxt = w_masked;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags  <= '0;
            r_csel_d <= CSEL_ZERO;
            r_err    <= 1'b0;
        end else if (!stall) begin
            r_flags  <= w_flags_nxt;
            r_csel_d <= carry_sel;
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    flag_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .FLAG_COUNT  (FLAG_COUNT)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_do_push),
        .pop   (w_do_pop),
        .din   (r_flags),
        .full  (w_full),
        .empty (w_empty),
        .top   (w_top)
    );

    always_comb begin
        carry_out = 1'b0;
        case (r_csel_d)
            CSEL_ZERO:  carry_out = 1'b0;
            CSEL_ONE:   carry_out = 1'b1;
            CSEL_ARITH: carry_out = r_flags[FLAG_AC];
            CSEL_LOGIC: carry_out = r_flags[FLAG_LC];
            default:    carry_out = 1'b0;
        endcase
    end

    assign flags_o     = r_flags;
    assign carry_sel_d = r_csel_d;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign stack_err   = r_err;

endmodule

// File: tb/tb_flags_unit.sv
// Directed self-checking bench for flags_unit with WIDTH=8, STACK_DEPTH=4.
module tb_flags_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic       stall;
    logic [7:0] data_in;
    logic [7:0] lhs_in;
    logic [7:0] rhs_in;
    logic       arith_carry_in;
    logic       logic_carry_in;
    logic [1:0] carry_sel;
    logic [4:0] update_mask;
    logic       load_en;
    logic [4:0] load_flags;
    logic       push;
    logic       pop;
    logic [4:0] flags_o;
    logic [1:0] carry_sel_d;
    logic       carry_out;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flags_unit #(
        .WIDTH       (8),
        .STACK_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .stall          (stall),
        .data_in        (data_in),
        .lhs_in         (lhs_in),
        .rhs_in         (rhs_in),
        .arith_carry_in (arith_carry_in),
        .logic_carry_in (logic_carry_in),
        .carry_sel      (carry_sel),
        .update_mask    (update_mask),
        .load_en        (load_en),
        .load_flags     (load_flags),
        .push           (push),
        .pop            (pop),
        .flags_o        (flags_o),
        .carry_sel_d    (carry_sel_d),
        .carry_out      (carry_out),
        .stack_full     (stack_full),
        .stack_empty    (stack_empty),
        .stack_err      (stack_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_off();
        valid_in = 1'b0;
        stall    = 1'b0;
        load_en  = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stack(input string tag, input logic full_e, input logic empty_e, input logic err_e);
        chk({tag, "_full"},  {31'd0, stack_full},  {31'd0, full_e});
        chk({tag, "_empty"}, {31'd0, stack_empty}, {31'd0, empty_e});
        chk({tag, "_err"},   {31'd0, stack_err},   {31'd0, err_e});
    endtask

    initial begin
        strobes_off();
        rst_n = 1'b0;
        data_in = 8'h00; lhs_in = 8'h00; rhs_in = 8'h00;
        arith_carry_in = 1'b0; logic_carry_in = 1'b0;
        carry_sel = 2'b11; update_mask = 5'h1F; load_flags = 5'h1F;
        tick(); tick();
        chk("rst_flags", {27'd0, flags_o}, 32'h00);
        chk("rst_csd", {30'd0, carry_sel_d}, 32'h0);
        chk("rst_cout", {31'd0, carry_out}, 32'h0);
        chk_stack("rst", 1'b0, 1'b1, 1'b0);

        // Signed overflow: 0x7F + 0x01 = 0x80 -> V S LC set
        rst_n = 1'b1;
        valid_in = 1'b1; lhs_in = 8'h7F; rhs_in = 8'h01; data_in = 8'h80;
        update_mask = 5'b11111; arith_carry_in = 1'b0; logic_carry_in = 1'b1;
        carry_sel = 2'b10;
        tick();
        chk("ovf_flags", {27'd0, flags_o}, 32'h1A);
        chk("ovf_csd", {30'd0, carry_sel_d}, 32'h2);
        chk("ovf_cout", {31'd0, carry_out}, 32'h0);

        // Z-only mask: AC input high must not reach the AC flag
        lhs_in = 8'h00; rhs_in = 8'h00; data_in = 8'h00;
        update_mask = 5'b00100; arith_carry_in = 1'b1;
        tick();
        chk("zmask_flags", {27'd0, flags_o}, 32'h1E);
        chk("zmask_cout", {31'd0, carry_out}, 32'h0);

        update_mask = 5'b00001;
        tick();
        chk("acmask_flags", {27'd0, flags_o}, 32'h1F);
        chk("acmask_cout", {31'd0, carry_out}, 32'h1);

        update_mask = 5'b00000; data_in = 8'h55; arith_carry_in = 1'b0; logic_carry_in = 1'b0;
        tick();
        chk("mask0_flags", {27'd0, flags_o}, 32'h1F);

        // Load beats valid update
        update_mask = 5'b11111; data_in = 8'h00;
        load_en = 1'b1; load_flags = 5'h15;
        tick();
        chk("load_flags", {27'd0, flags_o}, 32'h15);

        // Push saves pre-edge flags while load still applies
        valid_in = 1'b0; push = 1'b1; load_flags = 5'h00;
        tick();
        chk("push_flags", {27'd0, flags_o}, 32'h00);
        chk_stack("push1", 1'b0, 1'b0, 1'b0);

        // Pop beats load/valid
        push = 1'b0; load_en = 1'b0; pop = 1'b1;
        valid_in = 1'b1; data_in = 8'h01; arith_carry_in = 1'b1; logic_carry_in = 1'b1;
        tick();
        chk("pop_flags", {27'd0, flags_o}, 32'h15);
        chk_stack("pop1", 1'b0, 1'b1, 1'b0);

        // Fill the stack: entries 0x15,0x01,0x02,0x03
        strobes_off();
        push = 1'b1; load_en = 1'b1; load_flags = 5'h01;
        tick();
        load_flags = 5'h02;
        tick();
        load_flags = 5'h03;
        tick();
        chk_stack("push3", 1'b0, 1'b0, 1'b0);
        load_flags = 5'h04;
        tick();
        chk_stack("push4", 1'b1, 1'b0, 1'b0);
        chk("push4_flags", {27'd0, flags_o}, 32'h04);
        load_en = 1'b0;
        tick();
        chk_stack("push5", 1'b1, 1'b0, 1'b1);
        chk("push5_flags", {27'd0, flags_o}, 32'h04);

        // Drain in LIFO order; only four entries exist
        push = 1'b0; pop = 1'b1;
        tick();
        chk("drain1", {27'd0, flags_o}, 32'h03);
        chk("drain1_full", {31'd0, stack_full}, 32'h0);
        tick();
        chk("drain2", {27'd0, flags_o}, 32'h02);
        tick();
        chk("drain3", {27'd0, flags_o}, 32'h01);
        tick();
        chk("drain4", {27'd0, flags_o}, 32'h15);
        chk_stack("drain4", 1'b0, 1'b1, 1'b1);

        // Pop on empty holds flags even with load_en
        load_en = 1'b1; load_flags = 5'h0A;
        tick();
        chk("popempty_flags", {27'd0, flags_o}, 32'h15);
        chk_stack("popempty", 1'b0, 1'b1, 1'b1);

        // Stall holds carry_sel_d and flags for three cycles
        strobes_off();
        carry_sel = 2'b01;
        tick();
        chk("csel1_csd", {30'd0, carry_sel_d}, 32'h1);
        chk("csel1_cout", {31'd0, carry_out}, 32'h1);
        stall = 1'b1; valid_in = 1'b1; load_en = 1'b1; push = 1'b1;
        carry_sel = 2'b11;
        tick();
        chk("stall1_csd", {30'd0, carry_sel_d}, 32'h1);
        carry_sel = 2'b00;
        tick();
        chk("stall2_csd", {30'd0, carry_sel_d}, 32'h1);
        carry_sel = 2'b10;
        tick();
        chk("stall3_csd", {30'd0, carry_sel_d}, 32'h1);
        chk("stall3_flags", {27'd0, flags_o}, 32'h15);
        chk_stack("stall3", 1'b0, 1'b1, 1'b1);

        // Reset during stall with a non-empty stack
        strobes_off();
        push = 1'b1;
        tick();
        chk("prerst_empty", {31'd0, stack_empty}, 32'h0);
        stall = 1'b1; rst_n = 1'b0;
        tick();
        chk("stallrst_flags", {27'd0, flags_o}, 32'h00);
        chk("stallrst_csd", {30'd0, carry_sel_d}, 32'h0);
        chk("stallrst_cout", {31'd0, carry_out}, 32'h0);
        chk_stack("stallrst", 1'b0, 1'b1, 1'b0);

        // Push/pop conflict: stack untouched, load still applies
        strobes_off();
        rst_n = 1'b1;
        push = 1'b1; load_en = 1'b1; load_flags = 5'h07; carry_sel = 2'b11;
        tick();
        chk("cpush_flags", {27'd0, flags_o}, 32'h07);
        chk("cpush_cout", {31'd0, carry_out}, 32'h1);
        pop = 1'b1; load_flags = 5'h09;
        tick();
        chk("conflict_flags", {27'd0, flags_o}, 32'h09);
        chk_stack("conflict", 1'b0, 1'b0, 1'b1);
        chk("conflict_cout", {31'd0, carry_out}, 32'h0);
        strobes_off();
        pop = 1'b1;
        tick();
        chk("cpop_flags", {27'd0, flags_o}, 32'h00);
        chk_stack("cpop", 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/flags_unit.md
FLAGS_UNIT -- requirements
Module: flags_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: ALU datapath width, legal range 4..32.
REQ-002 SHALL have parameter STACK_DEPTH, default 4: flag save-stack entries, legal range 1..16.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port valid_in  in  1  ALU result valid this cycle.
REQ-006 SHALL have port stall  in  1  pipeline stall; holds all state.
REQ-007 SHALL have port data_in  in  WIDTH  ALU result.
REQ-008 SHALL have ports lhs_in, rhs_in  in  WIDTH  ALU operands.
REQ-009 SHALL have ports arith_carry_in, logic_carry_in  in  1  carry outputs from the arithmetic and logic units.
REQ-010 SHALL have port carry_sel  in  2  carry-select code for the next operation.
REQ-011 SHALL have port update_mask  in  5  per-flag write enable, bit order {V,S,Z,LC,AC}.
REQ-012 SHALL have ports load_en  in  1 and load_flags  in  5  direct flag write from the bus.
REQ-013 SHALL have ports push, pop  in  1  flag save-stack controls.
REQ-014 SHALL have port flags_o  out  5  registered flags, bit order {V,S,Z,LC,AC}.
REQ-015 SHALL have port carry_sel_d  out  2  carry_sel delayed by one accepted cycle.
REQ-016 SHALL have port carry_out  out  1  selected carry for the next ALU operation.
REQ-017 SHALL have ports stack_full, stack_empty  out  1  stack status.
REQ-018 SHALL have port stack_err  out  1  sticky stack overflow/underflow/conflict flag.

Function
REQ-019 SHALL compute combinationally: V=(lhs[W-1]^data[W-1])&(data[W-1]^rhs[W-1]); S=data[W-1]; Z=~|data; AC=arith_carry_in; LC=logic_carry_in.
REQ-020 SHALL register Z together with the other flags: every flag has 1-cycle latency from valid_in.
REQ-021 SHALL apply per-cycle priority: reset > stall > pop > load_en > valid_in update.
REQ-022 SHALL, on a valid_in update, write only the flags whose update_mask bit is 1; all other flags hold.
REQ-023 SHALL, when load_en is high and pop is low, write all five flags from load_flags, ignoring valid_in.
REQ-024 SHALL, on push, store the current flags_o (pre-edge value) on the stack; a flag update in the same cycle still proceeds.
REQ-025 SHALL, on pop with the stack not empty, load flags_o from the top entry and decrement the stack.
REQ-026 SHALL ignore push when full and pop when empty, leave flags and stack unchanged, and set stack_err.
REQ-027 SHALL treat push and pop in the same cycle as a conflict: no stack change, no pop load, stack_err set; load_en and valid_in still apply.
REQ-028 SHALL keep stack_err set until reset.
REQ-029 SHALL register carry_sel into carry_sel_d on every non-stalled cycle, regardless of valid_in.
REQ-030 SHALL drive carry_out combinationally from registers: carry_sel_d 00 -> 0, 01 -> 1, 10 -> AC, 11 -> LC.
REQ-031 SHALL drive stack_full and stack_empty combinationally from the stack count.
REQ-032 SHALL, while stall is high, ignore push, pop, load_en and valid_in, and hold all outputs.

Reset
REQ-033 SHALL, with rst_n low at a clock edge, clear flags_o=0, carry_sel_d=0, stack count=0 (stack_empty=1, stack_full=0) and stack_err=0; stored stack entries need no reset.
REQ-034 SHALL let reset override stall and all other inputs, including mid-push or mid-pop.

Structure
REQ-035 SHALL define the following in shared package flags_pkg: localparams FLAG_V/S/Z/LC/AC bit indices, FLAG_COUNT=5, and the carry-select encodings CSEL_ZERO/ONE/ARITH/LOGIC.
REQ-036 SHALL implement the LIFO in one sub-module, flag_stack, parametrised by STACK_DEPTH and FLAG_COUNT, with push, pop, full, empty and top outputs.

Verification
REQ-037 SHALL cover: W=8, valid_in, lhs=0x7F, rhs=0x01, data=0x80, mask=11111 -> next cycle flags_o V=1, S=1, Z=0.
REQ-038 SHALL cover: data=0x00, mask=00100 (Z only), AC=1 -> Z=1, AC holds its previous value.
REQ-039 SHALL cover: push with flags=0x15, update to 0x00, then pop -> flags_o=0x15, stack_empty=1.
REQ-040 SHALL cover: STACK_DEPTH=4 with 5 pushes -> stack_full=1 after the 4th, stack_err=1 after the 5th, count stays 4; then a pop on empty -> stack_err stays 1.
REQ-041 SHALL cover: carry_sel=10 with AC=1, then next cycle -> carry_out=1; stall held 3 cycles with carry_sel changing -> carry_sel_d unchanged.
REQ-042 SHALL cover: rst_n low during stall with a non-empty stack -> next cycle all outputs at reset values.
